// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the instruction-memory arbiter slice.
// Holds the default geometry, the arbitration state type and the fetch range check.
package instr_mem_pkg;

    localparam int DEPTH_DEF = 32;
    localparam int AW_DEF    = 5;

    typedef enum logic {
        LOAD_PRI  = 1'b0,
        FETCH_PRI = 1'b1
    } arb_state_t;

    function automatic logic word_in_range(input logic [31:0] addr,
                                           input int unsigned depth = DEPTH_DEF);
        return addr < (depth * 4);
    endfunction

endpackage

// File: rtl/instr_mem_arbiter_if.sv
// Fetch, loader and memory-side signals of the instruction-memory arbiter.
// master = CPU/loader/memory environment, slave = the arbiter itself.
interface instr_mem_arbiter_if #(
    parameter int AW = instr_mem_pkg::AW_DEF
);
    logic          f_req;
    logic [31:0]   f_addr;
    logic          f_gnt;
    logic          f_valid;
    logic [31:0]   f_instr;
    logic          f_err;

    logic          l_req;
    logic [AW-1:0] l_addr;
    logic [31:0]   l_wdata;
    logic          l_gnt;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport master (
        output f_req, f_addr, l_req, l_addr, l_wdata, mem_rdata,
        input  f_gnt, f_valid, f_instr, f_err, l_gnt,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  f_req, f_addr, l_req, l_addr, l_wdata, mem_rdata,
        output f_gnt, f_valid, f_instr, f_err, l_gnt,
               mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/instr_addr_check.sv
// Decodes a fetch byte address into a word index and flags misaligned/out-of-range PCs.
// Purely combinational, no latency, no backpressure.
module instr_addr_check
    import instr_mem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic [31:0]   addr,
    output logic [AW-1:0] word,
    output logic          err
);

    assign word = addr[AW+1:2];
    assign err  = (addr[1:0] != 2'b00) || !word_in_range(addr, DEPTH);

endmodule

// File: rtl/instr_mem_arbiter.sv
// Arbitrates the single-port instruction memory between fetch and loader; fetch data 1 cycle after grant.
// Requesters hold req until gnt; loader bursts are capped at MAX_BURST while fetch waits.
module instr_mem_arbiter
    import instr_mem_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int AW        = AW_DEF,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    instr_mem_arbiter_if.slave   bus
);

    localparam int            BW         = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    arb_state_t    state;
    logic [BW-1:0] burst_cnt;
    logic          valid_q;
    logic          rd_pend;
    logic          err_q;
    logic [31:0]   instr_q;

    logic [AW-1:0] f_word;
    logic          f_bad;
    logic          f_gnt;
    logic          l_gnt;

    instr_addr_check #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_addr_check (
        .addr  (bus.f_addr),
        .word  (f_word),
        .err   (f_bad)
    );

    // Grants are forced low while reset is held so nothing reaches the memory.
    always_comb begin
        f_gnt = 1'b0;
        l_gnt = 1'b0;
        if (rst_i) begin
            if (state == FETCH_PRI) begin
                f_gnt = bus.f_req;
                l_gnt = bus.l_req & ~bus.f_req;
            end else begin
                l_gnt = bus.l_req;
                f_gnt = bus.f_req & ~bus.l_req;
            end
        end
    end

    assign bus.f_gnt     = f_gnt;
    assign bus.l_gnt     = l_gnt;
    assign bus.mem_en    = l_gnt | (f_gnt & ~f_bad);
    assign bus.mem_we    = l_gnt;
    assign bus.mem_addr  = l_gnt ? bus.l_addr  : f_word;
    assign bus.mem_wdata = l_gnt ? bus.l_wdata : 32'h0;

    // The memory's read register is the first stage of f_instr; instr_q keeps it afterwards.
    assign bus.f_valid = valid_q;
    assign bus.f_err   = err_q;
    assign bus.f_instr = rd_pend ? bus.mem_rdata : instr_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= LOAD_PRI;
            burst_cnt <= '0;
            valid_q   <= 1'b0;
            rd_pend   <= 1'b0;
            err_q     <= 1'b0;
            instr_q   <= 32'h0;
        end else begin
            valid_q <= f_gnt;
            rd_pend <= f_gnt & ~f_bad;
            if (rd_pend) begin
                instr_q <= bus.mem_rdata;
            end
            if (f_gnt) begin
                err_q <= f_bad;
                if (f_bad) begin
                    instr_q <= 32'h0;
                end
            end

            case (state)
                LOAD_PRI: begin
                    if (!bus.f_req) begin
                        burst_cnt <= '0;
                    end else if (l_gnt) begin
                        if (burst_cnt == BURST_LAST) begin
                            state     <= FETCH_PRI;
                            burst_cnt <= '0;
                        end else begin
                            burst_cnt <= burst_cnt + 1'b1;
                        end
                    end else begin
                        // Fetch was served alone, so the loader streak is broken.
                        burst_cnt <= '0;
                    end
                end
                FETCH_PRI: begin
                    state     <= LOAD_PRI;
                    burst_cnt <= '0;
                end
                default: begin
                    state     <= LOAD_PRI;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

endmodule
